// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and FSM state type
// for the scheduled SPI master.
package spi_pkg;

  localparam int SPI_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SCK_HI,
    ST_SCK_LO,
    ST_FINISH,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// spi_rr_arb: round-robin arbiter, search starts after last.
// Ports: req (requests), last (last winner), win (one-hot), valid.
module spi_rr_arb
  import spi_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic            valid
);

  logic [IW-1:0] idx;

  always_comb begin
    win   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (!valid && req[idx]) begin
        win[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: mode-0 SPI master shared by NREQ requesters.
// Ports: CLK, RST_N, REQ, TXDATA in; GNT, DONE, RXDATA, BUSY,
// CS, SCK, MOSI out; MISO in. All outputs registered.
module spi_master_sched
  import spi_pkg::*;
#(
  parameter int HALF = 2,
  parameter int NREQ = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [NREQ-1:0]   REQ,
  input  logic [8*NREQ-1:0] TXDATA,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic [7:0]        RXDATA,
  output logic              BUSY,
  output logic [NREQ-1:0]   CS,
  output logic              SCK,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int CW = $clog2(HALF + 1);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t              st;
  logic [CW-1:0]       cnt;
  logic [2:0]          n;
  logic [SPI_BITS-1:0] tx;
  logic [SPI_BITS-1:0] rx;
  logic [NREQ-1:0]     sel;
  logic [IW-1:0]       last;

  logic [NREQ-1:0]     win;
  logic                win_ok;
  logic [IW-1:0]       win_idx;
  logic [7:0]          win_tx;
  logic                tick;
  logic                arb_pt;

  spi_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req   (REQ),
    .last  (last),
    .win   (win),
    .valid (win_ok)
  );

  always_comb begin
    win_idx = '0;
    win_tx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) begin
        win_idx = IW'(i);
        win_tx  = TXDATA[i*8 +: 8];
      end
    end
  end

  // Last cycle of the current half-period.
  assign tick   = (cnt == CW'(HALF - 1));
  // REQ only matters in IDLE or the final GAP cycle.
  assign arb_pt = (st == ST_IDLE) || (st == ST_GAP && tick);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      n      <= '0;
      tx     <= '0;
      rx     <= '0;
      sel    <= '0;
      last   <= IW'(NREQ - 1);
      GNT    <= '0;
      DONE   <= '0;
      RXDATA <= '0;
      BUSY   <= 1'b0;
      CS     <= '1;
      SCK    <= 1'b0;
      MOSI   <= 1'b0;
    end else begin
      GNT  <= '0;
      DONE <= '0;
      if (arb_pt && win_ok) begin
        st   <= ST_ASSERT;
        cnt  <= '0;
        n    <= '0;
        GNT  <= win;
        sel  <= win;
        CS   <= ~win;
        tx   <= win_tx;
        MOSI <= win_tx[0];
        BUSY <= 1'b1;
        last <= win_idx;
      end else if (st != ST_IDLE) begin
        if (!tick) begin
          cnt <= cnt + CW'(1);
        end else begin
          cnt <= '0;
          unique case (st)
            ST_ASSERT, ST_SCK_LO: begin
              st    <= ST_SCK_HI;
              SCK   <= 1'b1;
              rx[n] <= MISO;
            end
            ST_SCK_HI: begin
              SCK <= 1'b0;
              if (n == 3'(SPI_BITS - 1)) begin
                st <= ST_FINISH;
              end else begin
                st   <= ST_SCK_LO;
                n    <= n + 3'd1;
                MOSI <= tx[n + 3'd1];
              end
            end
            ST_FINISH: begin
              st     <= ST_GAP;
              CS     <= '1;
              DONE   <= sel;
              RXDATA <= rx;
            end
            ST_GAP: begin
              st   <= ST_IDLE;
              BUSY <= 1'b0;
            end
            default: st <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_sched.sv
// tb_spi_master_sched: timeline model of the SPI scheduler
// checked against the DUT every cycle, plus directed pins.
module tb_spi_master_sched;

  localparam int H = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST_N;
  logic [1:0]  req;
  logic [15:0] txd;
  logic [1:0]  gnt, done, cs;
  logic [7:0]  rxd;
  logic        busy, sck, mosi, miso;

  logic [1:0]  req1;
  logic [15:0] tx1d;
  logic [1:0]  gnt1, done1, cs1;
  logic [7:0]  rxd1;
  logic        busy1, sck1, mosi1, miso1;

  spi_master_sched #(.HALF(H), .NREQ(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(req), .TXDATA(txd),
    .GNT(gnt), .DONE(done), .RXDATA(rxd), .BUSY(busy),
    .CS(cs), .SCK(sck), .MOSI(mosi), .MISO(miso)
  );

  spi_master_sched #(.HALF(1), .NREQ(2)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .REQ(req1), .TXDATA(tx1d),
    .GNT(gnt1), .DONE(done1), .RXDATA(rxd1), .BUSY(busy1),
    .CS(cs1), .SCK(sck1), .MOSI(mosi1), .MISO(miso1)
  );

  assign miso1 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Slave: one shift register loaded on CS fall, MISO advances
  // on SCK fall, MOSI captured on SCK rise.
  logic [7:0] dout [2];
  logic [7:0] s_sh   = 8'h00;
  logic [7:0] s_din  = 8'h00;
  int         s_bit  = 0;
  int         s_rise = 0;
  logic [1:0] s_pcs  = 2'b11;
  logic       s_psck = 1'b0;

  always @(cs or sck) begin
    for (int i = 0; i < 2; i++)
      if (!cs[i] && s_pcs[i]) begin
        s_sh = dout[i]; s_bit = 0; s_rise = 0; s_din = 8'h00;
      end
    if (cs != 2'b11) begin
      if (sck && !s_psck) begin
        if (s_rise < 8) s_din[s_rise[2:0]] = mosi;
        s_rise++;
      end
      if (!sck && s_psck) s_bit++;
    end
    s_pcs  = cs;
    s_psck = sck;
  end

  assign miso = (cs != 2'b11 && s_bit < 8) ? s_sh[s_bit[2:0]] : 1'b0;

  // Model: a transfer is a timeline t = cycles since grant edge.
  bit         m_act;
  int         m_t, m_who, m_last;
  logic [7:0] m_tx, m_exprx, m_rxdata;
  logic       m_mosi;
  logic [1:0] e_gnt, e_done, e_cs;
  logic       e_sck, e_busy;

  task automatic model_reset();
    m_act = 0; m_t = 0; m_who = 0; m_last = 1;
    m_tx = 8'h00; m_exprx = 8'h00; m_rxdata = 8'h00; m_mosi = 1'b0;
  endtask

  task automatic model_step();
    int bi;
    logic [1:0] oh;
    if (m_act) begin
      m_t++;
      if (m_t == 18*H) m_act = 0;
    end
    if (!m_act)
      for (int k = 1; k <= 2; k++) begin
        int idx;
        idx = (m_last + k) % 2;
        if (!m_act && req[idx]) begin
          m_act = 1; m_t = 0; m_who = idx; m_last = idx;
          m_tx = txd[idx*8 +: 8]; m_exprx = dout[idx];
        end
      end
    e_gnt = 2'b00; e_done = 2'b00; e_cs = 2'b11;
    e_sck = 1'b0; e_busy = m_act;
    if (m_act) begin
      oh = 2'b01 << m_who;
      if (m_t == 0) e_gnt = oh;
      if (m_t < 17*H) e_cs = ~oh;
      e_sck = (m_t >= H) && (m_t < 16*H) && (((m_t - H) / H) % 2 == 0);
      if (m_t < 2*H) bi = 0;
      else bi = (m_t - 2*H) / (2*H) + 1;
      if (bi > 7) bi = 7;
      m_mosi = m_tx[bi[2:0]];
      if (m_t == 17*H) begin
        e_done = oh;
        m_rxdata = m_exprx;
      end
    end
  endtask

  int cyc_n = 0;
  int gnt_cnt0, gnt_cnt1, cs0_low, cs1_low, both_low, done_cnt;
  int r0, f1;
  logic [7:0] done_rx;
  logic [1:0] p_cs = 2'b11;
  int gq[$];
  logic [7:0] dq[$];

  task automatic phase_clear();
    gq.delete(); dq.delete();
    gnt_cnt0 = 0; gnt_cnt1 = 0; cs0_low = 0; cs1_low = 0;
    both_low = 0; done_cnt = 0; r0 = -1; f1 = -1; done_rx = 8'hEE;
  endtask

  task automatic compare();
    logic [16:0] a, e;
    cyc_n++;
    a = {gnt, done, cs, sck, mosi, busy, rxd};
    e = {e_gnt, e_done, e_cs, e_sck, m_mosi, e_busy, m_rxdata};
    chk($sformatf("outputs@%0d", cyc_n), 32'(a), 32'(e));
    if (e_done != 2'b00) begin
      chk("slave_din", {16'h0, s_rise[7:0], s_din}, {16'h0, 8'd8, m_tx});
      dq.push_back(s_din);
    end
    if (gnt[0]) begin gq.push_back(0); gnt_cnt0++; end
    if (gnt[1]) begin gq.push_back(1); gnt_cnt1++; end
    if (!cs[0]) cs0_low++;
    if (!cs[1]) cs1_low++;
    if (cs == 2'b00) both_low++;
    if (done != 2'b00) begin done_cnt++; done_rx = rxd; end
    if (cs[0] && !p_cs[0] && r0 < 0) r0 = cyc_n;
    if (!cs[1] && p_cs[1] && r0 >= 0 && f1 < 0) f1 = cyc_n;
    p_cs = cs;
  endtask

  task automatic cyc();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    compare();
  endtask

  task automatic wait_gnt(input int who);
    int g = 0;
    while (((who == 0) ? gnt_cnt0 : gnt_cnt1) == 0 && g < 100) begin
      cyc(); g++;
    end
    chk("gnt_wait", 32'(g < 100), 32'd1);
  endtask

  task automatic drain();
    int g = 0;
    while ((m_act || busy) && g < 200) begin cyc(); g++; end
    cyc();
    chk("drain", 32'(g < 200), 32'd1);
  endtask

  // HALF=1 instance sampler.
  logic       en1 = 1'b0;
  int         c1, low1, rises1, lastr1, badp1, dn1;
  logic [7:0] d1, rx1;
  logic       p1;

  always @(negedge CLK) begin
    if (!en1) begin
      c1 = 0; low1 = 0; rises1 = 0; lastr1 = -1; badp1 = 0;
      dn1 = 0; d1 = 8'h00; rx1 = 8'hEE; p1 = 1'b0;
    end else begin
      c1++;
      if (!cs1[0]) low1++;
      if (sck1 && !p1) begin
        if (rises1 < 8) d1[rises1[2:0]] = mosi1;
        if (lastr1 >= 0 && c1 - lastr1 != 2) badp1++;
        lastr1 = c1;
        rises1++;
      end
      p1 = sck1;
      if (done1 != 2'b00) begin dn1++; rx1 = rxd1; end
    end
  end

  initial begin
    int g;
    RST_N = 1'b0; req = 2'b00; txd = 16'h0; req1 = 2'b00; tx1d = 16'h0;
    dout[0] = 8'h00; dout[1] = 8'h00;
    model_reset();
    phase_clear();
    repeat (3) @(negedge CLK);
    chk("reset_state", 32'({gnt, done, cs, sck, mosi, busy, rxd}),
        32'({2'b00, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 8'h00}));
    chk("reset_cs_h1", 32'(cs1), 32'(2'b11));
    RST_N = 1'b1;

    // Both requesting from reset: 0 first, then alternate.
    phase_clear();
    req = 2'b11; txd = 16'h2211; dout[0] = 8'h5C; dout[1] = 8'hC5;
    g = 0;
    while (gq.size() < 4 && g < 400) begin cyc(); g++; end
    req = 2'b00;
    drain();
    chk("rr_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4)
      chk("rr_order", {28'h0, gq[0][0], gq[1][0], gq[2][0], gq[3][0]},
          32'b0101);
    chk("b2b_din0", 32'(dq.size() > 0 ? dq[0] : 8'hEE), 32'h11);
    chk("b2b_din1", 32'(dq.size() > 1 ? dq[1] : 8'hEE), 32'h22);
    chk("cs_gap", f1 - r0, 32'd2);
    chk("cs_both_low", both_low, 32'd0);

    // Single transfer from requester 0.
    phase_clear();
    txd = 16'h00A5; dout[0] = 8'h3C; req = 2'b01;
    wait_gnt(0);
    req = 2'b00;
    drain();
    chk("single_gnt", gnt_cnt0, 32'd1);
    chk("single_cs_low", cs0_low, 32'd34);
    chk("single_din", 32'(dq.size() > 0 ? dq[0] : 8'hEE), 32'hA5);
    chk("single_rx", 32'(done_rx), 32'h3C);

    // One-cycle REQ[1] pulse mid-transfer is ignored.
    phase_clear();
    txd = 16'h0077; dout[0] = 8'h96; req = 2'b01;
    wait_gnt(0);
    req = 2'b00;
    repeat (10) cyc();
    req = 2'b10;
    cyc();
    req = 2'b00;
    drain();
    chk("pulse_no_gnt1", gnt_cnt1, 32'd0);
    chk("pulse_no_cs1", cs1_low, 32'd0);
    chk("pulse_done", done_cnt, 32'd1);

    // Async reset after third SCK rise, then a clean transfer.
    phase_clear();
    txd = 16'h00C3; dout[0] = 8'h81; req = 2'b01;
    g = 0;
    while (s_rise < 3 && g < 100) begin cyc(); g++; end
    req = 2'b00;
    chk("abort_reach", 32'(g < 100), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    chk("abort_async", 32'({cs, sck, busy, gnt, done}),
        32'({2'b11, 1'b0, 1'b0, 2'b00, 2'b00}));
    chk("abort_no_done", done_cnt, 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    model_reset();
    RST_N = 1'b1;
    phase_clear();
    txd = 16'h5A00; dout[1] = 8'hE7; req = 2'b10;
    wait_gnt(1);
    req = 2'b00;
    drain();
    chk("post_rst_din", 32'(dq.size() > 0 ? dq[0] : 8'hEE), 32'h5A);
    chk("post_rst_rx", 32'(done_rx), 32'hE7);

    // Randomised traffic against the model.
    phase_clear();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) req = 2'($urandom);
      txd = 16'($urandom);
      if ($urandom_range(0, 9) == 0) dout[$urandom_range(0, 1)] = 8'($urandom);
      cyc();
    end
    req = 2'b00;
    drain();
    chk("rand_both_low", both_low, 32'd0);

    // HALF=1 instance.
    @(negedge CLK);
    #1 en1 = 1'b1;
    tx1d = 16'h00FF; req1 = 2'b01;
    g = 0;
    @(negedge CLK);
    while (gnt1 == 2'b00 && g < 10) begin @(negedge CLK); g++; end
    req1 = 2'b00;
    g = 0;
    while (dn1 == 0 && g < 40) begin @(negedge CLK); g++; end
    repeat (3) @(negedge CLK);
    chk("h1_done", dn1, 32'd1);
    chk("h1_cs_low", low1, 32'd17);
    chk("h1_rises", rises1, 32'd8);
    chk("h1_period", badp1, 32'd0);
    chk("h1_din", 32'(d1), 32'hFF);
    chk("h1_rx", 32'(rx1), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
